receiver: RTL
=============

Name: receiver

Overview:
- UART receive end; pairs with the existing transmitter on the same serial line.
- Frame format: 8N1, LSB first.
  - start bit = 0, lasting WAIT clocks
  - 8 data bits, WAIT clocks each
  - stop bit = 1, lasting WAIT clocks
- Deserialises uart_rx into a byte and presents it with a one-cycle valid strobe.
- Sits between the board RX pin and the consumer logic (command decoder / FIFO).

Parameters:
- WAIT, default 868, clock cycles per bit. Must equal the transmitter's WAIT (868 = 100 MHz / 115200). Legal range ≥ 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- uart_rx  input  1  serial line, idle high; asynchronous to clk.
- data  output  8  last correctly framed byte; held until the next good frame.
- valid  output  1  one-cycle pulse; data is new this cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (async assert; synchronous to clk on release):
  - data = 8'h00, valid = 0, frame_err = 0, busy = 0.
  - State = IDLE, bit counter = 0, cycle counter = 0.
  - Synchroniser flops preset to 1, so no false start is seen after reset.
- Input path: 2-flop synchroniser on uart_rx giving rx_s. All decisions use rx_s, which adds 2 cycles of latency.
- Cycle counter: counts 0..WAIT-1 and restarts at 0 on every state change.
- IDLE:
  - busy = 0.
  - rx_s == 0 in any cycle → START, counter = 0.
- START:
  - At counter == WAIT/2-1 (integer division), sample rx_s.
  - Sample 1 → glitch; return to IDLE with no output pulse.
  - Sample 0 → DATA, bit index = 0.
- DATA:
  - At counter == WAIT-1, sample rx_s and shift right into the shift register, inserting at the MSB, so bit 0 lands in data[0].
  - Bit index increments on each sample.
  - After the 8th sample → STOP.
- STOP:
  - At counter == WAIT-1 (mid stop bit), sample rx_s.
  - Sample 1: data ← shift register and valid = 1 in the next cycle.
  - Sample 0: frame_err = 1 in the next cycle; data is unchanged.
  - Either way, state → IDLE in that same next cycle.
- Timing summary:
  - Every sample point is at mid-bit.
  - The receiver re-enters IDLE about half a bit before the stop bit ends, so back-to-back frames from the transmitter are caught.
  - Latency: valid is asserted 2 + (WAIT/2) + 9·WAIT + 1 cycles after the start-bit falling edge reaches the uart_rx pin (±1 cycle for synchroniser phase).
- Output rules:
  - valid and frame_err are never high in the same cycle.
  - Neither is ever high for more than 1 cycle.
  - busy rises the cycle after rx_s is first seen low.
  - busy falls in the same cycle valid or frame_err is asserted.
- Line held low (break):
  - Produces frame_err once.
  - IDLE then sees rx_s == 0 and re-enters START, so a held-low line yields a frame_err every ~9.5 bit times. This is accepted behaviour.
- Reset mid-frame: abort immediately and drop the partial byte; data keeps its reset value of 00.

Optional Feature:
- Macro: RECEIVER_MAJORITY_EN.
- Defined:
  - Each data/stop sample is a 2-of-3 majority vote of rx_s at counter == WAIT-2, WAIT-1 and WAIT, referenced to the nominal mid-bit.
  - The start check votes at WAIT/2-2, WAIT/2-1 and WAIT/2.
  - Latency grows by 1 cycle; all counter limits shift accordingly.
- Undefined: single sample at the mid-bit point as described above.
- The port list is identical in both builds.

Test Plan:
- Reset, then drive one frame of 8'h5A with WAIT = 16 using the transmitter model → exactly one valid pulse, data == 8'h5A, frame_err never high, busy high from start edge until valid.
- Two back-to-back frames 8'hA5 then 8'hFF, no idle gap → two valid pulses ~10·WAIT apart, data 8'hA5 then 8'hFF.
- Glitch: uart_rx low for WAIT/4 cycles, then high → state returns to IDLE, no valid, no frame_err, busy high for < WAIT/2 + 3 cycles.
- Frame 8'h3C with stop bit forced 0 → frame_err single pulse, valid stays 0, data retains the previous value.
- Assert reset at bit 4 of a frame, release, then send 8'h81 → data == 8'h00 after reset, then 8'h81 with valid.
- With RECEIVER_MAJORITY_EN defined: 1-cycle low glitch exactly at the mid-bit of data bit 0 = 1 in 8'h01 → still decoded as 8'h01. Without the macro the same stimulus decodes as 8'h00.

Source files
------------

// File: rtl/receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | receiver : 8N1 UART receive end, LSB first, WAIT clocks per bit.           |
// | Option   : RECEIVER_MAJORITY_EN selects 2-of-3 voting around each sample.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module receiver #(
    parameter int WAIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    localparam int c_CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;

    // Voting takes one extra rx_s cycle past mid-bit, so the start decision moves out by one.
`ifdef RECEIVER_MAJORITY_EN
    localparam int c_START_INT = WAIT / 2;
`else
    localparam int c_START_INT = WAIT / 2 - 1;
`endif

    localparam logic [c_CNT_W-1:0] c_START_PT = c_CNT_W'(c_START_INT);
    localparam logic [c_CNT_W-1:0] c_BIT_PT   = c_CNT_W'(WAIT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_rx_meta;
    logic               r_rx_s;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;
    logic               w_sample;
    logic               w_start_pt;
    logic               w_bit_pt;

    // Presetting to 1 keeps a freshly reset receiver from seeing a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

`ifdef RECEIVER_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_rx_s};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
    assign w_sample = r_rx_s;
`endif

    assign w_start_pt = (r_cnt == c_START_PT);
    assign w_bit_pt   = (r_cnt == c_BIT_PT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (!r_rx_s) begin
                    w_next_state = c_START;
                end
            end
            c_START: begin
                if (w_start_pt) begin
                    w_next_state = w_sample ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (w_bit_pt && (r_bit_idx == 3'd7)) begin
                    w_next_state = c_STOP;
                end
            end
            c_STOP: begin
                if (w_bit_pt) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != c_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((w_next_state != r_state) || w_bit_pt) begin
            r_cnt <= '0;
        end else if (r_state != c_IDLE) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_idx <= 3'd0;
        end else if (r_state != c_DATA) begin
            r_bit_idx <= 3'd0;
        end else if (w_bit_pt) begin
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // Shift right with insertion at the MSB so the first (LSB) bit ends in bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            if ((r_state == c_DATA) && w_bit_pt) begin
                r_shift <= {w_sample, r_shift[7:1]};
            end
            if ((r_state == c_STOP) && w_bit_pt) begin
                if (w_sample) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
